alu_cmd_sequencer: RTL and testbench

Registered command front-end that drives the team's 8-bit combinational ALU. It sits between a valid/ready command source (CPU-side control or test driver) and the ALU's A/B/ALU_Sel inputs. It holds the operands stable for a programmable settle window, then captures the ALU result and carry. It returns them with status flags on a valid/ready response channel, and keeps an accumulator so chained operations can be issued.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_cmd_sequencer.sv | 97 +++++++++
 tb/tb_alu_cmd_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcode encodings, default widths, sequencer states.
// Opcode values must track the ALU_Sel decode of the combinational ALU.
package alu_pkg;
    localparam int ALU_WIDTH = 8;
    localparam int ALU_OP_W  = 4;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_SHL  = 4'b0100;
    localparam logic [3:0] ALU_SHR  = 4'b0101;
    localparam logic [3:0] ALU_ROL  = 4'b0110;
    localparam logic [3:0] ALU_ROR  = 4'b0111;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1011;
    localparam logic [3:0] ALU_NAND = 4'b1100;
    localparam logic [3:0] ALU_XNOR = 4'b1101;
    localparam logic [3:0] ALU_GT   = 4'b1110;
    localparam logic [3:0] ALU_EQ   = 4'b1111;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} seq_state_t;
endpackage

// File: rtl/alu_cmd_sequencer.sv
// Registered front-end for the combinational ALU: holds operands SETTLE_CYCLES edges, captures result.
// One command in flight; rsp_* held while stalled, cmd_ready only in IDLE.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = ALU_WIDTH,
    parameter int OP_W          = ALU_OP_W,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_dz,
    output logic [WIDTH-1:0] acc
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("alu_cmd_sequencer: SETTLE_CYCLES must be at least 1");
    end

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_eff;

    assign cmd_ready = (state == IDLE);
    // A clear arriving with the accept must already be visible to an accumulator-sourced operand.
    assign acc_eff   = acc_clr ? '0 : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_dz    <= 1'b0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_clr) acc <= '0;
                    if (cmd_valid) begin
                        alu_a   <= cmd_use_acc ? acc_eff : cmd_a;
                        alu_b   <= cmd_b;
                        alu_sel <= cmd_op;
                        cnt     <= CNT_W'(SETTLE_CYCLES - 1);
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        // Capture edge: the new result owns acc, a concurrent clear is dropped.
                        rsp_data  <= alu_out;
                        rsp_carry <= alu_carry & (alu_sel == OP_W'(ALU_ADD));
                        rsp_zero  <= (alu_out == '0);
                        rsp_dz    <= (alu_sel == OP_W'(ALU_DIV)) & (alu_b == '0);
                        acc       <= alu_out;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (acc_clr) acc <= '0;
                    end
                end
                RESP: begin
                    if (acc_clr) acc <= '0;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural ALU; one instance at SETTLE_CYCLES=1, one at 3.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       carry;
        logic       zero;
        logic       dz;
        logic [7:0] acc;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            ALU_ADD:  r = s[7:0];
            ALU_SUB:  r = a - b;
            ALU_MUL:  r = a * b;
            ALU_DIV:  r = (b == 8'd0) ? 8'hFF : a / b;
            ALU_SHL:  r = a << 1;
            ALU_SHR:  r = a >> 1;
            ALU_ROL:  r = {a[6:0], a[7]};
            ALU_ROR:  r = {a[0], a[7:1]};
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_NAND: r = ~(a & b);
            ALU_XNOR: r = ~(a ^ b);
            ALU_GT:   r = {7'd0, a > b};
            ALU_EQ:   r = {7'd0, a == b};
            default:  r = 8'd0;
        endcase
        return {s[8], r};
    endfunction

    // Instance 1 (SETTLE_CYCLES=1)
    logic       cmd_valid = 0, cmd_use_acc = 0, acc_clr = 0, rsp_ready = 1;
    logic [3:0] cmd_op = 0;
    logic [7:0] cmd_a = 0, cmd_b = 0;
    logic       cmd_ready, rsp_valid, rsp_carry, rsp_zero, rsp_dz, alu_carry;
    logic [7:0] alu_a, alu_b, alu_out, rsp_data, acc;
    logic [3:0] alu_sel;
    assign {alu_carry, alu_out} = alu_f(alu_sel, alu_a, alu_b);

    alu_cmd_sequencer #(.WIDTH(8), .OP_W(4), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .acc_clr(acc_clr), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .rsp_zero(rsp_zero), .rsp_dz(rsp_dz), .acc(acc)
    );

    // Instance 3 (SETTLE_CYCLES=3)
    logic       cmd_valid3 = 0, rsp_ready3 = 0;
    logic [3:0] cmd_op3 = 0;
    logic [7:0] cmd_a3 = 0, cmd_b3 = 0;
    logic       cmd_ready3, rsp_valid3, rsp_carry3, rsp_zero3, rsp_dz3, alu_carry3;
    logic [7:0] alu_a3, alu_b3, alu_out3, rsp_data3, acc3;
    logic [3:0] alu_sel3;
    assign {alu_carry3, alu_out3} = alu_f(alu_sel3, alu_a3, alu_b3);

    alu_cmd_sequencer #(.WIDTH(8), .OP_W(4), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op3), .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_use_acc(1'b0),
        .acc_clr(1'b0), .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
        .alu_out(alu_out3), .alu_carry(alu_carry3), .rsp_valid(rsp_valid3),
        .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_carry(rsp_carry3),
        .rsp_zero(rsp_zero3), .rsp_dz(rsp_dz3), .acc(acc3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitors: compare on each response handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u1_unexpected_rsp actual=%0h required=none", rsp_data);
            end else begin
                e1 = q1.pop_front();
                check("u1_rsp_data",  rsp_data,  e1.data);
                check("u1_rsp_carry", rsp_carry, e1.carry);
                check("u1_rsp_zero",  rsp_zero,  e1.zero);
                check("u1_rsp_dz",    rsp_dz,    e1.dz);
                check("u1_acc",       acc,       e1.acc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid3 && rsp_ready3) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u3_unexpected_rsp actual=%0h required=none", rsp_data3);
            end else begin
                e3 = q3.pop_front();
                check("u3_rsp_data",  rsp_data3,  e3.data);
                check("u3_rsp_carry", rsp_carry3, e3.carry);
                check("u3_rsp_zero",  rsp_zero3,  e3.zero);
                check("u3_rsp_dz",    rsp_dz3,    e3.dz);
                check("u3_acc",       acc3,       e3.acc);
            end
        end
    end

    task automatic wait_ready1();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("u1_cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic issue1(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic ua, input logic clr, input logic [7:0] exp_alu_a, input exp_t e);
        int n;
        wait_ready1();
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; acc_clr = clr; cmd_valid = 1;
        q1.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 0; acc_clr = 0; cmd_use_acc = 0;
        check("u1_alu_a",   alu_a,   exp_alu_a);
        check("u1_alu_b",   alu_b,   b);
        check("u1_alu_sel", alu_sel, op);
        check("u1_cmd_ready_busy", cmd_ready, 0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("u1_latency", n, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_alu_a"},     alu_a,     0);
        check({tag, "_alu_b"},     alu_b,     0);
        check({tag, "_alu_sel"},   alu_sel,   0);
        check({tag, "_rsp_data"},  rsp_data,  0);
        check({tag, "_flags"},     {rsp_carry, rsp_zero, rsp_dz}, 0);
        check({tag, "_acc"},       acc,       0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_reset_outputs("reset");
        #10 rst_n = 1;
        check("reset_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        // Test 1 and 2: ADD with carry, chained SUB on acc
        issue1(ALU_ADD, 8'hF0, 8'h20, 0, 0, 8'hF0, '{8'h10, 1'b1, 1'b0, 1'b0, 8'h10});
        issue1(ALU_ADD, 8'h05, 8'h03, 0, 0, 8'h05, '{8'h08, 1'b0, 1'b0, 1'b0, 8'h08});
        issue1(ALU_SUB, 8'hAA, 8'h08, 1, 0, 8'h08, '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00});
        // Test 3: divide by zero and normal divide
        issue1(ALU_DIV, 8'h40, 8'h00, 0, 0, 8'h40, '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF});
        issue1(ALU_DIV, 8'h40, 8'h04, 0, 0, 8'h40, '{8'h10, 1'b0, 1'b0, 1'b0, 8'h10});
        // Carry forced low for non-ADD; dz only for DIV
        issue1(ALU_AND, 8'hFF, 8'hFF, 0, 0, 8'hFF, '{8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF});
        issue1(ALU_XOR, 8'h5A, 8'h00, 0, 0, 8'h5A, '{8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A});

        // acc_clr in IDLE
        wait_ready1();
        acc_clr = 1;
        @(posedge clk); #1;
        acc_clr = 0;
        check("idle_acc_clr", acc, 0);

        // Test 5: clear coincident with accept of accumulator-sourced OR
        issue1(ALU_ADD, 8'h05, 8'h03, 0, 0, 8'h05, '{8'h08, 1'b0, 1'b0, 1'b0, 8'h08});
        issue1(ALU_OR,  8'hCC, 8'h0F, 1, 1, 8'h00, '{8'h0F, 1'b0, 1'b0, 1'b0, 8'h0F});

        // Test 4: MUL with SETTLE_CYCLES=3 and a 5-cycle stall
        begin
            int n = 0;
            while (!cmd_ready3 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            check("u3_cmd_ready_wait", cmd_ready3, 1);
            cmd_op3 = ALU_MUL; cmd_a3 = 8'h10; cmd_b3 = 8'h10; cmd_valid3 = 1; rsp_ready3 = 0;
            q3.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 8'h00});
            @(posedge clk); #1;
            cmd_valid3 = 0;
            for (int k = 0; k < 3; k++) begin
                check("u3_settle_alu", {alu_a3, alu_b3, 4'd0, alu_sel3}, {8'h10, 8'h10, 4'd0, ALU_MUL});
                check("u3_settle_rsp_valid", rsp_valid3, 0);
                check("u3_settle_cmd_ready", cmd_ready3, 0);
                @(posedge clk); #1;
            end
            for (int k = 0; k < 5; k++) begin
                check("u3_stall_rsp_valid", rsp_valid3, 1);
                check("u3_stall_rsp", {rsp_data3, 5'd0, rsp_carry3, rsp_zero3, rsp_dz3}, {8'h00, 5'd0, 3'b010});
                check("u3_stall_cmd_ready", cmd_ready3, 0);
                @(posedge clk); #1;
            end
            rsp_ready3 = 1;
            @(posedge clk); #1;
            rsp_ready3 = 0;
            check("u3_post_hs_rsp_valid", rsp_valid3, 0);
            check("u3_post_hs_cmd_ready", cmd_ready3, 1);
        end

        // Test 6: reset during SETTLE drops the GT command
        wait_ready1();
        check("pre_reset_acc", acc, 8'h0F);
        cmd_op = ALU_GT; cmd_a = 8'h80; cmd_b = 8'h7F; cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
        check("gt_in_settle", cmd_ready, 0);
        #1 rst_n = 0;
        #1 check_reset_outputs("midrst");
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1;
        check("midrst_cmd_ready", cmd_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("midrst_no_rsp", rsp_valid, 0);
        end
        issue1(ALU_EQ, 8'h33, 8'h33, 0, 0, 8'h33, '{8'h01, 1'b0, 1'b0, 1'b0, 8'h01});

        repeat (3) @(posedge clk);
        #1;
        check("u1_queue_empty", q1.size(), 0);
        check("u3_queue_empty", q3.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
